legv8_multicycle_ctrl: RTL and testbench

//  Multicycle control unit for the LEGv8 datapath. Drives the complete datapath control word

---
 rtl/legv8_multicycle_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_legv8_multicycle_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/legv8_multicycle_ctrl.sv
// Multicycle LEGv8 control unit: FETCH/EXEC/MEM_LD/MEM_ST/HALT sequencer with memory wait timeout.
// Optional B.cond decode is enabled by defining LEGV8_BCOND_EN.
module legv8_multicycle_ctrl #(
  parameter int unsigned MemTimeout = 255,
  parameter int unsigned ToW        = 8
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [31:0] ir_out_i,
  input  logic [3:0]  status_i,
  input  logic [3:0]  sr_out_i,
  input  logic        mem_ready_i,
  output logic [4:0]  da_o,
  output logic [4:0]  sa_o,
  output logic [4:0]  sb_o,
  output logic        w_o,
  output logic        il_o,
  output logic        sl_o,
  output logic [4:0]  fs_o,
  output logic        c0_o,
  output logic [1:0]  ps_o,
  output logic        pc_sel_o,
  output logic        b_sel_o,
  output logic        en_alu_o,
  output logic        en_b_o,
  output logic        en_pc_o,
  output logic        en_addr_alu_o,
  output logic        en_addr_pc_o,
  output logic [63:0] constant_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        halted_o,
  output logic        fault_o
);

  typedef enum logic [2:0] {StFetch, StExec, StMemLd, StMemSt, StHalt} state_e;

  localparam logic [4:0] FsAnd = 5'b00000;
  localparam logic [4:0] FsOrr = 5'b00100;
  localparam logic [4:0] FsAdd = 5'b01000;
  localparam logic [4:0] FsSub = 5'b01010;

  state_e         state_q, state_d;
  logic [ToW-1:0] cnt_q, cnt_d;
  logic           fault_q, fault_d;

  logic [10:0] op11;
  logic [9:0]  op10;
  logic [7:0]  op8;
  logic [5:0]  op6;
  assign op11 = ir_out_i[31:21];
  assign op10 = ir_out_i[31:22];
  assign op8  = ir_out_i[31:24];
  assign op6  = ir_out_i[31:26];

  logic is_add, is_sub, is_and, is_orr, is_adds, is_subs, is_addi, is_subi;
  logic is_ldur, is_stur, is_b, is_cbz, is_cbnz, is_rtype, is_legal, cb_taken;
  assign is_add   = (op11 == 11'b10001011000);
  assign is_sub   = (op11 == 11'b11001011000);
  assign is_and   = (op11 == 11'b10001010000);
  assign is_orr   = (op11 == 11'b10101010000);
  assign is_adds  = (op11 == 11'b10101011000);
  assign is_subs  = (op11 == 11'b11101011000);
  assign is_addi  = (op10 == 10'b1001000100);
  assign is_subi  = (op10 == 10'b1101000100);
  assign is_ldur  = (op11 == 11'b11111000010);
  assign is_stur  = (op11 == 11'b11111000000);
  assign is_b     = (op6 == 6'b000101);
  assign is_cbz   = (op8 == 8'b10110100);
  assign is_cbnz  = (op8 == 8'b10110101);
  assign is_rtype = is_add | is_sub | is_and | is_orr | is_adds | is_subs;
  assign cb_taken = is_cbz ? status_i[0] : ~status_i[0];

  logic is_bcond, bcond_taken;
`ifdef LEGV8_BCOND_EN
  // Flags are {V,C,N,Z}.
  assign is_bcond = (op8 == 8'b01010100);
  always_comb begin
    bcond_taken = 1'b0;
    case (ir_out_i[3:0])
      4'b0000: bcond_taken = sr_out_i[0];
      4'b0001: bcond_taken = ~sr_out_i[0];
      4'b1010: bcond_taken = (sr_out_i[1] == sr_out_i[3]);
      4'b1011: bcond_taken = (sr_out_i[1] != sr_out_i[3]);
      default: bcond_taken = 1'b0;
    endcase
  end
`else
  assign is_bcond    = 1'b0;
  assign bcond_taken = 1'b0;
  logic unused_sr;
  assign unused_sr = ^sr_out_i;
`endif

  logic unused_status;
  assign unused_status = ^status_i[3:1];

  assign is_legal = is_rtype | is_addi | is_subi | is_ldur | is_stur | is_b | is_cbz | is_cbnz |
                    is_bcond;

  logic wait_st, timeout;
  assign wait_st = (state_q == StFetch) || (state_q == StMemLd) || (state_q == StMemSt);
  assign timeout = wait_st && !mem_ready_i && (cnt_q == ToW'(MemTimeout));

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StFetch;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: begin
        if (mem_ready_i)  state_d = StExec;
        else if (timeout) state_d = StHalt;
      end
      StExec: begin
        if (is_ldur)       state_d = StMemLd;
        else if (is_stur)  state_d = StMemSt;
        else if (is_legal) state_d = StFetch;
        else               state_d = StHalt;
      end
      StMemLd, StMemSt: begin
        if (mem_ready_i)  state_d = StFetch;
        else if (timeout) state_d = StHalt;
      end
      default: state_d = StHalt;
    endcase
    // Any state change restarts the wait count for the next access.
    if (state_d != state_q)            cnt_d = '0;
    else if (wait_st && !mem_ready_i)  cnt_d = cnt_q + ToW'(1);
    else                               cnt_d = cnt_q;
    fault_d = fault_q | timeout;
  end

  always_comb begin
    da_o = '0; sa_o = '0; sb_o = '0;
    w_o = 1'b0; il_o = 1'b0; sl_o = 1'b0;
    fs_o = '0; c0_o = 1'b0; ps_o = 2'b00;
    pc_sel_o = 1'b0; b_sel_o = 1'b0;
    en_alu_o = 1'b0; en_b_o = 1'b0; en_pc_o = 1'b0;
    en_addr_alu_o = 1'b0; en_addr_pc_o = 1'b0;
    constant_o = '0;
    mem_read_o = 1'b0; mem_write_o = 1'b0;
    halted_o = 1'b0; fault_o = 1'b0;
    if (!reset_i) begin
      fault_o = fault_q;
      case (state_q)
        StFetch: begin
          en_addr_pc_o = 1'b1;
          mem_read_o   = 1'b1;
          il_o         = mem_ready_i;
        end
        StExec: begin
          if (is_rtype) begin
            sa_o = ir_out_i[9:5]; sb_o = ir_out_i[20:16]; da_o = ir_out_i[4:0];
            en_alu_o = 1'b1; w_o = 1'b1; ps_o = 2'b01;
            sl_o = is_adds | is_subs;
            if (is_sub | is_subs)      begin fs_o = FsSub; c0_o = 1'b1; end
            else if (is_and)           fs_o = FsAnd;
            else if (is_orr)           fs_o = FsOrr;
            else                       fs_o = FsAdd;
          end else if (is_addi | is_subi) begin
            sa_o = ir_out_i[9:5]; da_o = ir_out_i[4:0];
            b_sel_o = 1'b1; constant_o = {52'b0, ir_out_i[21:10]};
            en_alu_o = 1'b1; w_o = 1'b1; ps_o = 2'b01;
            fs_o = is_subi ? FsSub : FsAdd;
            c0_o = is_subi;
          end else if (is_b) begin
            constant_o = {{38{ir_out_i[25]}}, ir_out_i[25:0]};
            pc_sel_o = 1'b1; ps_o = 2'b11;
          end else if (is_cbz | is_cbnz) begin
            sa_o = ir_out_i[4:0]; sb_o = 5'd31; fs_o = FsAdd;
            if (cb_taken) begin
              constant_o = {{45{ir_out_i[23]}}, ir_out_i[23:5]};
              pc_sel_o = 1'b1; ps_o = 2'b11;
            end else begin
              ps_o = 2'b01;
            end
          end else if (is_bcond) begin
            if (bcond_taken) begin
              constant_o = {{45{ir_out_i[23]}}, ir_out_i[23:5]};
              pc_sel_o = 1'b1; ps_o = 2'b11;
            end else begin
              ps_o = 2'b01;
            end
          end
        end
        StMemLd, StMemSt: begin
          sa_o = ir_out_i[9:5]; b_sel_o = 1'b1; fs_o = FsAdd; en_addr_alu_o = 1'b1;
          constant_o = {{55{ir_out_i[20]}}, ir_out_i[20:12]};
          if (state_q == StMemLd) begin
            mem_read_o = 1'b1;
            if (mem_ready_i) begin da_o = ir_out_i[4:0]; w_o = 1'b1; ps_o = 2'b01; end
          end else begin
            sb_o = ir_out_i[4:0]; en_b_o = 1'b1; mem_write_o = 1'b1;
            if (mem_ready_i) ps_o = 2'b01;
          end
        end
        default: halted_o = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Scoreboard bench for legv8_multicycle_ctrl: driver queues expected control words per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_legv8_multicycle_ctrl;

  localparam int unsigned MemTimeout = 255;

  typedef struct packed {
    logic [4:0]  da, sa, sb;
    logic        w, il, sl;
    logic [4:0]  fs;
    logic        c0;
    logic [1:0]  ps;
    logic        pc_sel, b_sel, en_alu, en_b, en_pc, en_addr_alu, en_addr_pc;
    logic [63:0] imm;
    logic        mem_read, mem_write, halted, fault;
  } cw_t;

  typedef struct {
    string name;
    cw_t   cw;
  } exp_t;

  logic        clock, reset, mem_ready;
  logic [31:0] ir;
  logic [3:0]  status, sr;
  logic [4:0]  da, sa, sb, fs;
  logic        w, il, sl, c0, pc_sel, b_sel, en_alu, en_b, en_pc, en_addr_alu, en_addr_pc;
  logic [1:0]  ps;
  logic [63:0] konst;
  logic        mem_read, mem_write, halted, fault;
  cw_t         act;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  legv8_multicycle_ctrl #(.MemTimeout(MemTimeout), .ToW(8)) dut (
    .clock_i(clock), .reset_i(reset), .ir_out_i(ir), .status_i(status), .sr_out_i(sr),
    .mem_ready_i(mem_ready), .da_o(da), .sa_o(sa), .sb_o(sb), .w_o(w), .il_o(il), .sl_o(sl),
    .fs_o(fs), .c0_o(c0), .ps_o(ps), .pc_sel_o(pc_sel), .b_sel_o(b_sel), .en_alu_o(en_alu),
    .en_b_o(en_b), .en_pc_o(en_pc), .en_addr_alu_o(en_addr_alu), .en_addr_pc_o(en_addr_pc),
    .constant_o(konst), .mem_read_o(mem_read), .mem_write_o(mem_write), .halted_o(halted),
    .fault_o(fault)
  );

  assign act = {da, sa, sb, w, il, sl, fs, c0, ps, pc_sel, b_sel, en_alu, en_b, en_pc,
                en_addr_alu, en_addr_pc, konst, mem_read, mem_write, halted, fault};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  exp_t e;
  always @(negedge clock) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      n_vec++;
      if (act !== e.cw) begin
        n_err++;
        $display("FAIL %s: got %h want %h", e.name, act, e.cw);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic expect_cw(input string nm, input cw_t cw);
    exp_t x;
    x.name = nm;
    x.cw   = cw;
    q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic cw_t cw_fetch();
    cw_t c = '0;
    c.en_addr_pc = 1'b1; c.mem_read = 1'b1; c.il = 1'b1;
    return c;
  endfunction

  function automatic cw_t cw_alu(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                                 input logic [4:0] f, input logic cin, input logic s);
    cw_t c = '0;
    c.da = d; c.sa = a; c.sb = b; c.fs = f; c.c0 = cin; c.sl = s;
    c.en_alu = 1'b1; c.w = 1'b1; c.ps = 2'b01;
    return c;
  endfunction

  function automatic cw_t cw_mem(input logic st, input logic [4:0] a, input logic [4:0] rt,
                                 input logic [63:0] off, input logic rdy);
    cw_t c = '0;
    c.sa = a; c.b_sel = 1'b1; c.imm = off; c.fs = 5'b01000; c.en_addr_alu = 1'b1;
    if (st) begin
      c.sb = rt; c.en_b = 1'b1; c.mem_write = 1'b1;
      if (rdy) c.ps = 2'b01;
    end else begin
      c.mem_read = 1'b1;
      if (rdy) begin c.da = rt; c.w = 1'b1; c.ps = 2'b01; end
    end
    return c;
  endfunction

  task automatic do_fetch(input string nm, input logic [31:0] instr);
    ir = instr;
    mem_ready = 1'b1;
    expect_cw({nm, "_fetch"}, cw_fetch());
    tick();
  endtask

  task automatic do_reset(input string nm);
    reset = 1'b1;
    expect_cw(nm, '0);
    tick();
    reset = 1'b0;
  endtask

  cw_t c;
  logic [31:0] i_add, i_subs, i_and, i_addi, i_ldur, i_stur, i_cbz, i_b, i_bne;

  initial begin
    i_add  = {11'b10001011000, 5'd2, 6'd0, 5'd1, 5'd3};
    i_subs = {11'b11101011000, 5'd0, 6'd0, 5'd0, 5'd0};
    i_and  = {11'b10001010000, 5'd6, 6'd0, 5'd5, 5'd4};
    i_addi = {10'b1001000100, 12'd5, 5'd2, 5'd1};
    i_ldur = {11'b11111000010, 9'h1F8, 2'b00, 5'd2, 5'd5};
    i_stur = {11'b11111000000, 9'd16, 2'b00, 5'd3, 5'd9};
    i_cbz  = {8'b10110100, 19'd4, 5'd7};
    i_b    = {6'b000101, 26'h3FF_FFFF};
    i_bne  = {8'b01010100, 19'd3, 5'b00001};

    reset = 1'b1; ir = '0; status = '0; sr = '0; mem_ready = 1'b0;
    @(posedge clock); #1;
    expect_cw("reset_idle", '0);
    tick();
    mem_ready = 1'b1; ir = i_add;
    expect_cw("reset_ready_no_il", '0);
    tick();
    reset = 1'b0;

    do_fetch("add", i_add);
    expect_cw("add_exec", cw_alu(5'd3, 5'd1, 5'd2, 5'b01000, 1'b0, 1'b0));
    tick();

    status = 4'b0001;
    do_fetch("subs", i_subs);
    expect_cw("subs_exec", cw_alu(5'd0, 5'd0, 5'd0, 5'b01010, 1'b1, 1'b1));
    tick();

    do_fetch("and", i_and);
    expect_cw("and_exec", cw_alu(5'd4, 5'd5, 5'd6, 5'b00000, 1'b0, 1'b0));
    tick();

    do_fetch("addi", i_addi);
    c = cw_alu(5'd1, 5'd2, 5'd0, 5'b01000, 1'b0, 1'b0);
    c.b_sel = 1'b1; c.imm = 64'd5;
    expect_cw("addi_exec", c);
    tick();

    do_fetch("ldur", i_ldur);
    expect_cw("ldur_exec", '0);
    tick();
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expect_cw("ldur_wait", cw_mem(1'b0, 5'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0));
      tick();
    end
    mem_ready = 1'b1;
    expect_cw("ldur_done", cw_mem(1'b0, 5'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1));
    tick();

    status = 4'b0001;
    do_fetch("cbz_t", i_cbz);
    c = '0; c.sa = 5'd7; c.sb = 5'd31; c.fs = 5'b01000; c.imm = 64'd4; c.pc_sel = 1'b1;
    c.ps = 2'b11;
    expect_cw("cbz_taken", c);
    tick();
    status = 4'b0000;
    do_fetch("cbz_n", i_cbz);
    c = '0; c.sa = 5'd7; c.sb = 5'd31; c.fs = 5'b01000; c.ps = 2'b01;
    expect_cw("cbz_not_taken", c);
    tick();

    do_fetch("b", i_b);
    c = '0; c.imm = '1; c.pc_sel = 1'b1; c.ps = 2'b11;
    expect_cw("b_exec", c);
    tick();

    // Reset in the middle of a store access must drop the strobe immediately.
    do_fetch("stur_rst", i_stur);
    expect_cw("stur_rst_exec", '0);
    tick();
    mem_ready = 1'b0;
    expect_cw("stur_wait", cw_mem(1'b1, 5'd3, 5'd9, 64'd16, 1'b0));
    tick();
    do_reset("mid_store_reset");

    sr = 4'b0000;
    do_fetch("bne", i_bne);
`ifdef LEGV8_BCOND_EN
    c = '0; c.imm = 64'd3; c.pc_sel = 1'b1; c.ps = 2'b11;
    expect_cw("bne_taken", c);
    tick();
`else
    expect_cw("bne_illegal_exec", '0);
    tick();
    c = '0; c.halted = 1'b1;
    expect_cw("bne_illegal_halt", c);
    tick();
`endif
    do_reset("reset_after_bne");

    do_fetch("illegal", 32'h0);
    expect_cw("illegal_exec", '0);
    tick();
    c = '0; c.halted = 1'b1;
    expect_cw("illegal_halt", c);
    tick();
    expect_cw("illegal_halt_hold", c);
    tick();
    do_reset("reset_after_illegal");

    do_fetch("stur_to", i_stur);
    expect_cw("stur_to_exec", '0);
    tick();
    mem_ready = 1'b0;
    for (int k = 0; k < int'(MemTimeout); k++) begin
      expect_cw("stur_to_wait", cw_mem(1'b1, 5'd3, 5'd9, 64'd16, 1'b0));
      tick();
    end
    tick();
    c = '0; c.halted = 1'b1; c.fault = 1'b1;
    expect_cw("timeout_halt_fault", c);
    tick();
    do_reset("reset_clears_fault");

    do_fetch("add_after", i_add);
    expect_cw("add_after_exec", cw_alu(5'd3, 5'd1, 5'd2, 5'b01000, 1'b0, 1'b0));
    tick();

    tick();
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
